prog_loader: RTL
================

// Module: prog_loader
// PURPOSE
//  Boot-time program loader sitting upstream of the CPU/program memory in the SoC top.
//  Accepts a byte stream (valid/ready), assembles little-endian 32-bit words and writes them into PROGMEM from word 0.
//  Holds the CPU in reset until a complete image with a correct checksum has been written.
//  Lets benches and a future UART boot path load programs instead of relying on a preinitialised PROGMEM.
// PARAMETERS
//  ADDR_W   9   word-address width of PROGMEM (512 words = 2 KB, byte addresses 0..2047)
// PORTS
//  clk          in   1       system clock, all logic on rising edge
//  rst          in   1       asynchronous, active-low reset (rst==0 resets)
//  in_valid     in   1       byte available on in_data
//  in_data      in   8       stream byte
//  in_ready     out  1       loader accepts byte; transfer = in_valid & in_ready
//  mem_we       out  1       PROGMEM write strobe, one cycle per word
//  mem_addr     out  ADDR_W  PROGMEM word address
//  mem_wdata    out  32      word to write
//  cpu_rst      out  1       active-high reset to the CPU; 1 until a good image has loaded
//  done         out  1       image loaded, checksum good (sticky)
//  err          out  1       load failed (sticky until rst)
//  words_loaded out  16      count of words written
// BEHAVIOUR
//  Stream format: LEN_L, LEN_H (N, 16-bit LE word count), 4*N data bytes (LE per word), CSUM (XOR of all data bytes).
//  Reset (async, rst==0): state=LEN0, in_ready=0 during reset, mem_we=0, mem_addr=0, mem_wdata=0,
//   cpu_rst=1, done=0, err=0, words_loaded=0, byte index=0, running XOR=0. Reset mid-load abandons the image.
//  FSM states: LEN0 -> LEN1 -> DATA -> CSUM -> DONE, plus ERR.
//   LEN0: accept byte -> N[7:0]; go LEN1.
//   LEN1: accept byte -> N[15:8]. If N > 2**ADDR_W, go ERR. If N==0, go CSUM. Otherwise go DATA.
//   DATA: accept bytes into word[8*i+:8], i=0..3, and XOR each byte into csum.
//    On the 4th byte, the next cycle has mem_we=1, mem_wdata=word, mem_addr=current index.
//    The index then increments and words_loaded increments in the same cycle as mem_we.
//    After word N-1, go CSUM.
//   CSUM: accept byte. If it equals the running XOR, go DONE; otherwise go ERR.
//   DONE: done=1, cpu_rst=0 (registered, deasserts the cycle after entry), in_ready=0. Held until rst.
//   ERR:  err=1, cpu_rst stays 1, in_ready=0. Held until rst.
//  in_ready = 1 in LEN0, LEN1, DATA and CSUM; 0 otherwise. A full byte per cycle is sustained.
//  Gaps in in_valid stall the FSM with no state change; mem_we is never asserted without a completed word.
//  Write latency: 1 cycle after the 4th byte handshake.
//  Back-to-back words: mem_we may be asserted in the cycle that accepts the next word's byte 0.
//  Address width: mem_addr wraps nowhere. N is bounded by the LEN1 check, so the last address is N-1 <= 2**ADDR_W-1.
//  words_loaded saturates naturally at N (<= 2**ADDR_W).
//  done and err are mutually exclusive. cpu_rst==0 implies done==1.
// STRUCTURE
//  Shared package/header (loader_defs.vh): state encodings LD_LEN0..LD_ERR, LEN_BYTES=2, WORD_BYTES=4.
//  One sub-module, byte_packer: 4-byte shift/assemble with byte index and word_valid pulse.
//  The FSM, address counter, checksum and cpu_rst generation live in prog_loader.
//  In top: the mem0 write port is muxed to the loader while cpu_rst==1; cpu0 rst is driven by (cpu_rst | ~rst).
// TESTING
//  1. N=3, words 0x00000013, 0x00100093, 0xDEADBEEF, correct CSUM:
//     -> 3 mem_we pulses at addr 0,1,2 with exact data, words_loaded=3, done=1, cpu_rst=0, err=0.
//  2. N=0, CSUM=0x00 -> no mem_we, done=1, cpu_rst=0.
//     Repeat with CSUM=0x01 -> err=1, cpu_rst=1.
//  3. N=2 with a wrong CSUM byte (XOR^0xFF) -> both words written, then err=1, done=0, cpu_rst=1, in_ready=0.
//  4. N=513 with ADDR_W=9 -> err=1 right after LEN_H, zero mem_we, in_ready=0 afterwards.
//  5. N=2 with in_valid toggling randomly (gaps of 0..5 cycles) -> identical writes to the gap-free run.
//     mem_we is never asserted during gaps between bytes of one word.
//  6. Pull rst low after 6 data bytes of an N=4 image, then reload N=1 word 0x12345678:
//     -> outputs take reset values during rst; afterwards one write to addr 0, done=1.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and stream framing.
package prog_loader_pkg;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [2:0] {
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_CSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/prog_loader_byte_packer.sv
// Assembles accepted bytes little-endian into a 32-bit word and pulses word_valid
// for one cycle after the fourth byte of each word.
module byte_packer
  import prog_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid,
  output logic [1:0]  idx
);

  // Place each byte in its lane; the pulse follows the last lane by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word       <= '0;
      word_valid <= 1'b0;
      idx        <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_en) begin
        word[{idx, 3'b000} +: 8] <= byte_in;
        idx                      <= idx + 2'd1;
        if (idx == 2'(WORD_BYTES - 1)) begin
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses LEN_L, LEN_H, 4*N data bytes, CSUM from a valid/ready byte
// stream, writes words into program memory from word 0 and releases the CPU reset
// only after a complete image with a matching XOR checksum.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [15:0]       words_loaded
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  ld_state_t   state;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [1:0]  idx;
  logic        word_valid;
  logic [31:0] word;
  logic        take;
  logic        data_en;
  logic        last_word;
  logic [16:0] len_next;

  assign take      = in_valid & in_ready;
  assign data_en   = take & (state == LD_DATA);
  assign len_next  = {1'b0, in_data, len[7:0]};
  // The previous word's write (and address bump) always lands before this word's
  // fourth byte, so mem_addr is the index of the word being assembled.
  assign last_word = (17'(mem_addr) + 17'd1) == {1'b0, len};

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .byte_en    (data_en),
    .byte_in    (in_data),
    .word       (word),
    .word_valid (word_valid),
    .idx        (idx)
  );

  assign mem_we    = word_valid;
  assign mem_wdata = word;

  // Address and word counters advance at the end of each write cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr     <= '0;
      words_loaded <= '0;
    end else if (word_valid) begin
      mem_addr     <= mem_addr + ADDR_W'(1);
      words_loaded <= words_loaded + 16'd1;
    end
  end

  // Stream parser FSM with registered ready/status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= LD_LEN0;
      in_ready <= 1'b0;
      len      <= '0;
      csum     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
    end else begin
      case (state)
        LD_LEN0: begin
          in_ready <= 1'b1;
          if (take) begin
            len[7:0] <= in_data;
            state    <= LD_LEN1;
          end
        end
        LD_LEN1: begin
          if (take) begin
            len[15:8] <= in_data;
            if (len_next > MAX_WORDS) begin
              state    <= LD_ERR;
              in_ready <= 1'b0;
            end else if (len_next == 17'd0) begin
              state <= LD_CSUM;
            end else begin
              state <= LD_DATA;
            end
          end
        end
        LD_DATA: begin
          if (data_en) begin
            csum <= csum ^ in_data;
            if (idx == 2'(WORD_BYTES - 1) && last_word) begin
              state <= LD_CSUM;
            end
          end
        end
        LD_CSUM: begin
          if (take) begin
            state    <= (in_data == csum) ? LD_DONE : LD_ERR;
            in_ready <= 1'b0;
          end
        end
        LD_DONE: begin
          in_ready <= 1'b0;
          done     <= 1'b1;
          cpu_rst  <= 1'b0;
        end
        LD_ERR: begin
          in_ready <= 1'b0;
          err      <= 1'b1;
        end
        default: begin
          state    <= LD_ERR;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule
